// File: rtl/seq_detect_pkg.sv
// Shared types for the serial "1101" detector controller.
// FSM and detector state encodings plus the target pattern.
package seq_detect_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } fsm_e;

  typedef enum logic [1:0] {
    S0,
    S1,
    S11,
    S110
  } det_e;

  localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq_detect_core.sv
// Overlapping Mealy detector for PATTERN, one bit per enabled cycle.
// State is frozen while en is low so matches can span idle gaps.
module seq_detect_core
  import seq_detect_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic din,
  output logic y
);

  det_e st_q, st_d;

  always_ff @(posedge clk) begin
    if (!reset) st_q <= S0;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    y    = 1'b0;
    if (en) begin
      unique case (st_q)
        S0:   st_d = (din == PATTERN[3]) ? S1 : S0;
        S1:   st_d = (din == PATTERN[2]) ? S11 : S0;
        S11:  st_d = (din == PATTERN[1]) ? S110 : S11;
        S110: begin
          if (din == PATTERN[0]) begin
            y    = 1'b1;
            st_d = S1;
          end else begin
            st_d = S0;
          end
        end
        default: st_d = S0;
      endcase
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-to-bit serializer feeding the pattern detector,
// with a saturating hit counter and a sticky threshold irq.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  thresh,
  input  logic              clr_cnt,
  output logic              ser_bit,
  output logic              hit,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic              irq,
  output logic              busy
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  fsm_e              fsm_q, fsm_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              irq_q, irq_d;
  logic              accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q <= IDLE;
      sh_q  <= '0;
      idx_q <= '0;
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      sh_q  <= sh_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  always_comb begin
    busy     = (fsm_q == SHIFT);
    in_ready = !busy || (idx_q == '0);
    ser_bit  = busy ? sh_q[idx_q] : 1'b0;
    accept   = in_valid && in_ready;
    fsm_d    = fsm_q;
    sh_d     = sh_q;
    idx_d    = idx_q;
    unique case (fsm_q)
      IDLE: begin
        if (accept) begin
          fsm_d = SHIFT;
          sh_d  = in_data;
          idx_d = IDX_TOP;
        end
      end
      SHIFT: begin
        if (idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else if (accept) begin
          sh_d  = in_data;
          idx_d = IDX_TOP;
        end else begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // A hit coinciding with clr_cnt is dropped: clear takes priority.
  always_comb begin
    cnt_d = cnt_q;
    irq_d = irq_q;
    if (clr_cnt) begin
      cnt_d = '0;
      irq_d = 1'b0;
    end else if (hit && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
      if (thresh != '0 && cnt_d == thresh) irq_d = 1'b1;
    end
  end

  seq_detect_core u_core (
    .clk   (clk),
    .reset (reset),
    .en    (busy),
    .din   (ser_bit),
    .y     (hit)
  );

  assign hit_cnt = cnt_q;
  assign irq     = irq_q;

endmodule
